// File: rtl/ioport_cmd_master.sv
// ----------------------------------------------------------------------------
// ioport_cmd_master
//
// Host-side initiator for the UART I/O-port command protocol. A 32-bit port
// read or write request becomes a byte sequence on a UART byte interface. For a
// read, the block also collects the four response bytes.
//
//   Write frame : cmd, wdata[31:24], wdata[23:16], wdata[15:8], wdata[7:0]
//   Read frame  : cmd, then 4 response bytes received MSB first
//   cmd byte    : {we, 3'b000, addr}
//
// Ports
//   clock, reset_n   master clock; synchronous active-low reset
//   req/we/addr/wdata  request, sampled only while idle
//   busy             transaction in progress
//   done             one-cycle pulse at end of transaction (busy already low)
//   rdata            last successful read result
//   timeout_err      valid with done; held until the next accepted request
//   txen/txready/txdata  UART transmitter load strobe / ready / byte
//   rxready/rxdata   UART receiver byte-valid pulse / byte
//
// Parameters
//   TIMEOUT_CYCLES   maximum clocks allowed between response bytes
//   TMO_W            timeout counter width, 2**TMO_W > TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module ioport_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TMO_W          = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout_err,
  output logic        txen,
  input  logic        txready,
  output logic [7:0]  txdata,
  input  logic        rxready,
  input  logic [7:0]  rxdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TXCMD  = 3'd1,
    ST_TXGAP  = 3'd2,
    ST_TXDATA = 3'd3,
    ST_RXDATA = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic              tmo_err_q;
  logic [7:0]        txdata_q;
  logic              we_q;
  logic [31:0]       wsr_q;    // write data, shifted out MSB byte first
  logic [31:0]       rsr_q;    // read response assembly
  logic [2:0]        cnt_q;    // data bytes sent (write) or received (read)
  logic [TMO_W-1:0]  tmo_q;

  logic [31:0]       rsr_d;
  logic [2:0]        cnt_d;
  logic [TMO_W-1:0]  tmo_d;

  // Next-state values for the shift register and counters.
  always_comb begin
    rsr_d = {rsr_q[23:0], rxdata};
    cnt_d = cnt_q + 3'd1;
    tmo_d = tmo_q + TMO_W'(1);
  end

  // The load strobe is tied to txready in the same cycle, so a byte is never
  // offered while the transmitter is not ready. txdata is already stable from
  // the state entry.
  assign txen = ((state_q == ST_TXCMD) || (state_q == ST_TXDATA)) && txready;

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign timeout_err = tmo_err_q;
  assign txdata      = txdata_q;

  // Transaction sequencer with registered status and data outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      tmo_err_q <= 1'b0;
      txdata_q  <= 8'h00;
      we_q      <= 1'b0;
      wsr_q     <= 32'h0000_0000;
      rsr_q     <= 32'h0000_0000;
      cnt_q     <= 3'd0;
      tmo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q      <= we;
            wsr_q     <= wdata;
            txdata_q  <= {we, 3'b000, addr};
            busy_q    <= 1'b1;
            tmo_err_q <= 1'b0;
            cnt_q     <= 3'd0;
            state_q   <= ST_TXCMD;
          end
        end

        ST_TXCMD: begin
          if (txready) begin
            if (we_q) begin
              state_q <= ST_TXGAP;
            end else begin
              // The response may start as soon as the command is loaded, so
              // the read path skips the gap cycle.
              tmo_q   <= '0;
              cnt_q   <= 3'd0;
              state_q <= ST_RXDATA;
            end
          end
        end

        ST_TXGAP: begin
          // One cycle in which txready is not looked at. This lets the
          // transmitter drop ready after the load strobe.
          if (cnt_q == 3'd4) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            txdata_q <= wsr_q[31:24];
            wsr_q    <= {wsr_q[23:0], 8'h00};
            state_q  <= ST_TXDATA;
          end
        end

        ST_TXDATA: begin
          if (txready) begin
            cnt_q   <= cnt_d;
            state_q <= ST_TXGAP;
          end
        end

        ST_RXDATA: begin
          // An arriving byte takes priority over the timeout terminal count.
          if (rxready) begin
            rsr_q <= rsr_d;
            cnt_q <= cnt_d;
            tmo_q <= '0;
            if (cnt_q == 3'd3) begin
              rdata_q <= rsr_d;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end else if (tmo_q == TMO_LAST) begin
            tmo_err_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_FIN;
          end else begin
            tmo_q <= tmo_d;
          end
        end

        ST_FIN: begin
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ioport_cmd_master.sv
module tb_ioport_cmd_master;

  localparam int TMO = 100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, timeout_err, txen;
  logic [31:0] rdata;
  logic [7:0]  txdata;
  logic        txready = 1'b1;
  logic        rxready = 1'b0;
  logic [7:0]  rxdata = 8'h00;

  ioport_cmd_master #(.TIMEOUT_CYCLES(TMO), .TMO_W(20)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .timeout_err(timeout_err), .txen(txen), .txready(txready),
    .txdata(txdata), .rxready(rxready), .rxdata(rxdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] rdata;
    logic        tmo;
  } res_t;

  logic [7:0]  exp_tx[$];
  res_t        exp_res[$];
  logic [31:0] rdata_mdl = 32'h0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every txen pops an expected byte, every done pops a result.
  always @(negedge clock) begin
    if (reset_n) begin
      if (txen) begin
        check("txen_rdy", {31'h0, txready}, 32'd1);
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", {31'h0, txen}, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          check("txdata", {24'h0, txdata}, {24'h0, e});
        end
      end
      if (done) begin
        check("done_busy", {31'h0, busy}, 32'd0);
        if (exp_res.size() == 0) begin
          check("done_unexpected", {31'h0, done}, 32'd0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("rdata", rdata, r.rdata);
          check("tmo_err", {31'h0, timeout_err}, {31'h0, r.tmo});
        end
      end
    end
  end

  // Issue one request while idle; expected tx bytes are queued up front.
  task automatic start(input logic w, input logic [3:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    exp_tx.push_back({w, 3'b000, a});
    if (w) begin
      exp_tx.push_back(d[31:24]);
      exp_tx.push_back(d[23:16]);
      exp_tx.push_back(d[15:8]);
      exp_tx.push_back(d[7:0]);
      exp_res.push_back('{rdata: rdata_mdl, tmo: 1'b0});
    end
    @(posedge clock); #1;
    req = 1'b0;
  endtask

  // Count falling edges until done is seen; an expired budget is a failure.
  task automatic wait_done(input string tag, output int n);
    for (n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (done) return;
    end
    check(tag, 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clock);
    @(posedge clock); #1;
    rxready = 1'b1; rxdata = b;
    @(posedge clock); #1;
    rxready = 1'b0; rxdata = 8'h00;
  endtask

  // Read transaction: nb response bytes from d (MSB first), then completion.
  task automatic do_read(input logic [3:0] a, input logic [31:0] d, input int nb,
                         input int gap, output int lat);
    if (nb == 4) begin
      exp_res.push_back('{rdata: d, tmo: 1'b0});
      rdata_mdl = d;
    end else begin
      exp_res.push_back('{rdata: rdata_mdl, tmo: 1'b1});
    end
    start(1'b0, a, 32'h0);
    for (int i = 0; i < nb; i++) begin
      logic [31:0] t;
      t = d << (8 * i);
      send_byte(t[31:24], gap);
    end
    wait_done("rd_done", lat);
  endtask

  initial begin
    int n;
    logic found;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_txen", {31'h0, txen}, 32'd0);
    check("rst_tmo", {31'h0, timeout_err}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_txdata", {24'h0, txdata}, 32'h0);
    reset_n = 1'b1;

    // Write with txready always high: 5 bytes, done in cycle 12
    start(1'b1, 4'h3, 32'hDEADBEEF);
    check("wr_busy", {31'h0, busy}, 32'd1);
    wait_done("wr_done", n);
    check("wr_latency", n + 2, 32'd12);
    check("wr_txleft", exp_tx.size(), 32'd0);

    // Read of port 7 with response 12 34 56 78
    do_read(4'h7, 32'h12345678, 4, 2, n);
    check("rd_latency", n, 32'd0);

    // Read with uneven response spacing
    do_read(4'hF, 32'h80000001, 4, 7, n);
    check("rd2_latency", n, 32'd0);

    // Read answered with 2 bytes only: timeout TMO cycles after 2nd byte
    do_read(4'h2, 32'hAABBCCDD, 2, 3, n);
    check("tmo_latency", n, TMO);
    repeat (5) @(negedge clock);
    check("tmo_hold", {31'h0, timeout_err}, 32'd1);

    // Write with txready low 50 cycles before every byte
    txready = 1'b0;
    start(1'b1, 4'hA, 32'h0102A5F0);
    check("tmo_clr", {31'h0, timeout_err}, 32'd0);
    for (int b = 0; b < 5; b++) begin
      repeat (50) @(negedge clock);
      check("slow_busy", {31'h0, busy}, 32'd1);
      @(posedge clock); #1;
      txready = 1'b1;
      @(negedge clock);
      check("slow_txen", {31'h0, txen}, 32'd1);
      @(posedge clock); #1;
      txready = 1'b0;
    end
    wait_done("slow_done", n);
    txready = 1'b1;

    // Back-to-back: second req raised in the done cycle, accepted one cycle later
    start(1'b1, 4'h2, 32'hC0FFEE11);
    wait_done("b2b_done1", n);
    req = 1'b1; we = 1'b1; addr = 4'h6; wdata = 32'h5A5A0F0F;
    exp_tx.push_back(8'h86);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'h0F);
    exp_tx.push_back(8'h0F);
    exp_res.push_back('{rdata: rdata_mdl, tmo: 1'b0});
    @(negedge clock);
    check("b2b_idle", {31'h0, busy}, 32'd0);
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    check("b2b_busy", {31'h0, busy}, 32'd1);
    wait_done("b2b_done2", n);
    check("b2b_latency", n + 2, 32'd11);

    // Reset during the 3rd write data byte
    start(1'b1, 4'h5, 32'h11223344);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (txen && txdata == 8'h33) found = 1'b1;
    end
    check("rst_found", {31'h0, found}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    exp_tx.delete();
    exp_res.delete();
    rdata_mdl = 32'h0;
    check("mid_busy", {31'h0, busy}, 32'd0);
    check("mid_txen", {31'h0, txen}, 32'd0);
    check("mid_done", {31'h0, done}, 32'd0);
    check("mid_rdata", rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    send_byte(8'hAA, 1);
    repeat (20) @(negedge clock);
    check("idle_busy", {31'h0, busy}, 32'd0);
    do_read(4'h9, 32'hCAFEF00D, 4, 2, n);
    check("post_rst_lat", n, 32'd0);

    repeat (5) @(negedge clock);
    check("end_txq", exp_tx.size(), 32'd0);
    check("end_resq", exp_res.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
